// File: rtl/mem_arbiter_pkg.sv
// Shared constants, state encoding and owner encoding for the two-client memory arbiter.
// The state encoding is fixed so the memory-model checker can decode the debug state port.
package mem_arbiter_pkg;

  localparam int MEM_ADDR_BITS = 28;
  localparam int MEM_DATA_BITS = 128;
  localparam int MEM_BEATS     = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    WDATA = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IC = 1'b0,
    OWN_DC = 1'b1
  } owner_e;

  // One-hot grant bit positions used by the picker.
  localparam int GNT_IC = 0;
  localparam int GNT_DC = 1;

  function automatic int cnt_bits(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Memory request/response bundle: command, write-data and read-response channels.
// The requester side (cache, or the arbiter toward DRAM) uses the master modport.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_BITS = MEM_ADDR_BITS,
  parameter int DATA_BITS = MEM_DATA_BITS
) ();

  // Every channel transfers on a rising edge where valid and ready are both high;
  // the sender holds its payload stable while valid is high. resp has no ready.
  logic                   req_valid;
  logic                   req_ready;
  logic [ADDR_BITS-1:0]   req_addr;
  logic                   req_rw;
  logic                   req_data_valid;
  logic                   req_data_ready;
  logic [DATA_BITS-1:0]   req_data_bits;
  logic [DATA_BITS/8-1:0] req_data_mask;
  logic                   resp_valid;
  logic [DATA_BITS-1:0]   resp_data;

  modport master (
    output req_valid, req_addr, req_rw,
    output req_data_valid, req_data_bits, req_data_mask,
    input  req_ready, req_data_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_addr, req_rw,
    input  req_data_valid, req_data_bits, req_data_mask,
    output req_ready, req_data_ready, resp_valid, resp_data
  );

endinterface

// File: rtl/mem_arb_rr_picker.sv
// Combinational two-way grant picker; the last-grant pointer is held by the parent.
// Optional build macro: MEM_ARB_FIXED_PRIO_EN (D$ wins every tie, pointer ignored).
module mem_arb_rr_picker
  import mem_arbiter_pkg::*;
(
  input  logic       req_ic,
  input  logic       req_dc,
  input  logic       last_dc,
  output logic [1:0] grant
);

`ifdef MEM_ARB_FIXED_PRIO_EN
  logic unused_last_dc;
  assign unused_last_dc = last_dc;
`endif

  always_comb begin
    grant = '0;
    if (req_ic && req_dc) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      grant[GNT_DC] = 1'b1;
`else
      // Tie goes to whichever client was not served last.
      if (last_dc) grant[GNT_IC] = 1'b1;
      else         grant[GNT_DC] = 1'b1;
`endif
    end else if (req_dc) begin
      grant[GNT_DC] = 1'b1;
    end else if (req_ic) begin
      grant[GNT_IC] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-client (I$/D$) memory arbiter: one transaction at a time onto the DRAM port.
// Optional build macro: MEM_ARB_FIXED_PRIO_EN (see mem_arb_rr_picker).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_BITS = MEM_ADDR_BITS,
  parameter int DATA_BITS = MEM_DATA_BITS,
  parameter int BEATS     = MEM_BEATS
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  ic,
  mem_arbiter_if.slave  dc,
  mem_arbiter_if.master mem,
  output arb_state_e    state,
  output owner_e        owner
);

  localparam int CNT_BITS = cnt_bits(BEATS);
  localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(BEATS - 1);

  logic [CNT_BITS-1:0]    cnt;
  owner_e                 last_grant;
  logic [1:0]             grant;
  logic                   own_dc;
  logic [ADDR_BITS-1:0]   own_addr;
  logic                   own_rw;
  logic                   own_data_valid;
  logic [DATA_BITS-1:0]   own_data_bits;
  logic [DATA_BITS/8-1:0] own_data_mask;
  logic                   wdata_hs;
  logic                   resp_beat;
  logic                   last_beat;

  mem_arb_rr_picker u_picker (
    .req_ic  (ic.req_valid),
    .req_dc  (dc.req_valid),
    .last_dc (last_grant == OWN_DC),
    .grant   (grant)
  );

  assign own_dc         = (owner == OWN_DC);
  assign own_addr       = own_dc ? dc.req_addr       : ic.req_addr;
  assign own_rw         = own_dc ? dc.req_rw         : ic.req_rw;
  assign own_data_valid = own_dc ? dc.req_data_valid : ic.req_data_valid;
  assign own_data_bits  = own_dc ? dc.req_data_bits  : ic.req_data_bits;
  assign own_data_mask  = own_dc ? dc.req_data_mask  : ic.req_data_mask;

  assign wdata_hs  = (state == WDATA) && own_data_valid && mem.req_data_ready;
  assign resp_beat = (state == RESP) && mem.resp_valid;
  assign last_beat = (cnt == LAST_CNT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= OWN_DC;
      cnt        <= '0;
      last_grant <= OWN_DC;
    end else begin
      case (state)
        IDLE: begin
          if (|grant) begin
            owner <= grant[GNT_DC] ? OWN_DC : OWN_IC;
            state <= CMD;
          end
        end
        CMD: begin
          if (mem.req_ready) begin
            cnt   <= '0;
            state <= own_rw ? WDATA : RESP;
          end
        end
        WDATA, RESP: begin
          // Count stops at the last beat, so it never wraps mid-transaction.
          if (wdata_hs || resp_beat) begin
            if (last_beat) begin
              state      <= IDLE;
              last_grant <= owner;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory side
  assign mem.req_valid      = (state == CMD);
  assign mem.req_addr       = own_addr;
  assign mem.req_rw         = own_rw;
  assign mem.req_data_valid = (state == WDATA) && own_data_valid;
  assign mem.req_data_bits  = own_data_bits;
  assign mem.req_data_mask  = own_data_mask;

  // Client side: only the owner ever sees a ready or a response beat.
  assign ic.req_ready      = (state == CMD)   && !own_dc && mem.req_ready;
  assign dc.req_ready      = (state == CMD)   &&  own_dc && mem.req_ready;
  assign ic.req_data_ready = (state == WDATA) && !own_dc && mem.req_data_ready;
  assign dc.req_data_ready = (state == WDATA) &&  own_dc && mem.req_data_ready;
  assign ic.resp_valid     = resp_beat && !own_dc;
  assign dc.resp_valid     = resp_beat &&  own_dc;
  assign ic.resp_data      = mem.resp_data;
  assign dc.resp_data      = mem.resp_data;

  a_resp_exclusive : assert property (@(posedge clk) disable iff (!reset)
    !(ic.resp_valid && dc.resp_valid));
  a_ready_exclusive : assert property (@(posedge clk) disable iff (!reset)
    !(ic.req_ready && dc.req_ready) && !(ic.req_data_ready && dc.req_data_ready));

endmodule
